wb_pattern_engine: RTL

Synthesizable, parametrised Wishbone master that exercises the SDRAM controller: writes a programmable data pattern over an address window in configurable-length incrementing bursts, reads it back and self-checks. It sits on the controller's Wishbone port in place of the task-based stimulus, so long soak and multi-width regressions can run without testbench code on the bus.

---
 rtl/wbpg_pkg.sv | 33 +++
 rtl/wbpg_pattern_gen.sv | 67 ++++++
 rtl/wb_pattern_engine.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wbpg_pkg.sv
// Shared types and constants for the Wishbone pattern engine.
// States, pattern selectors, CTI codes, LFSR taps and the watchdog limit.
package wbpg_pkg;

  typedef enum logic [2:0] {StIdle, StWr, StWrGap, StRd, StRdGap, StFin} state_e;
  typedef enum logic [1:0] {PatIncr, PatWalk, PatLfsr, PatInv} pat_e;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  // Right-shifting Galois taps, maximal length for each supported width.
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Abort on the 4095th consecutive stalled cycle.
  localparam logic [11:0] WDOG_LIMIT = 12'd4094;

  function automatic logic [31:0] lfsr_taps(input int unsigned dw);
    logic [31:0] taps;
    case (dw)
      8:       taps = LFSR_TAPS_8;
      16:      taps = LFSR_TAPS_16;
      default: taps = LFSR_TAPS_32;
    endcase
    return taps;
  endfunction

  function automatic logic [2:0] cti_of(input logic [3:0] beats_left);
    return (beats_left == 4'd1) ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/wbpg_pattern_gen.sv
// Pattern word generator shared by write and read phases.
// o_word is registered and always holds the word for the current index.
module wbpg_pattern_gen
  import wbpg_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_restart,
  input  logic          i_advance,
  input  pat_e          i_pat,
  input  logic [DW-1:0] i_seed,
  output logic [DW-1:0] o_word
);

  localparam logic [31:0]   TapsAll = lfsr_taps(DW);
  localparam logic [DW-1:0] Taps    = TapsAll[DW-1:0];
  localparam int unsigned   SW      = $clog2(DW);

  logic [LEN_W-1:0] r_idx;
  logic [DW-1:0]    r_lfsr;
  logic [DW-1:0]    r_word;

  logic [LEN_W-1:0] w_idx_nxt;
  logic [DW-1:0]    w_lfsr_nxt;
  logic [DW-1:0]    w_seed;

  function automatic logic [DW-1:0] word_of(input pat_e pat, input logic [LEN_W-1:0] idx,
                                            input logic [DW-1:0] lfsr);
    logic [DW-1:0] w;
    w = '0;
    case (pat)
      PatIncr: w = DW'(idx);
      PatWalk: w = {{(DW-1){1'b0}}, 1'b1} << idx[SW-1:0];
      PatLfsr: w = lfsr;
      PatInv:  w = ~DW'(idx);
      default: w = '0;
    endcase
    return w;
  endfunction

  assign w_idx_nxt  = r_idx + LEN_W'(1);
  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ Taps) : (r_lfsr >> 1);
  // An all-zero LFSR would lock up, so a zero seed becomes all ones.
  assign w_seed     = (i_seed == '0) ? '1 : i_seed;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_lfsr <= '0;
      r_word <= '0;
    end else if (i_restart) begin
      r_idx  <= '0;
      r_lfsr <= w_seed;
      r_word <= word_of(i_pat, '0, w_seed);
    end else if (i_advance) begin
      r_idx  <= w_idx_nxt;
      r_lfsr <= w_lfsr_nxt;
      r_word <= word_of(i_pat, w_idx_nxt, w_lfsr_nxt);
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/wb_pattern_engine.sv
// Wishbone master that writes a pattern over a window in bursts, reads it back and checks it.
// Define WBPG_TIMEOUT_EN to add a 12-bit stalled-ack watchdog that aborts the run.
module wb_pattern_engine
  import wbpg_pkg::*;
#(
  parameter int unsigned APP_AW    = 26,
  parameter int unsigned DW        = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [APP_AW-1:0] cfg_base_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [3:0]        cfg_burst_i,
  input  logic [1:0]        cfg_pat_i,
  input  logic [DW-1:0]     cfg_seed_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       err_cnt_o,
  output logic [APP_AW-1:0] first_err_addr_o,
  output logic              timeout_o
);

  localparam logic [APP_AW-1:0] AddrStep = APP_AW'(DW / 8);
  localparam logic [3:0]        BurstMax = 4'(BURST_MAX);

  state_e            r_state;
  logic [APP_AW-1:0] r_base, r_addr, r_first_err;
  logic [LEN_W-1:0]  r_len, r_rem;
  logic [3:0]        r_burst, r_bleft;
  pat_e              r_pat;
  logic [DW-1:0]     r_seed;
  logic              r_cyc, r_stb, r_we, r_busy, r_done;
  logic [2:0]        r_cti;
  logic [15:0]       r_err;

  logic              w_ack;
  logic              w_restart;
  logic [3:0]        w_burst_cfg;
  pat_e              w_gen_pat;
  logic [DW-1:0]     w_gen_seed;
  logic [DW-1:0]     w_word;

  function automatic logic [3:0] first_bl(input logic [LEN_W-1:0] rem, input logic [3:0] burst);
    return (rem < LEN_W'(burst)) ? rem[3:0] : burst;
  endfunction

  assign w_ack       = r_stb & wb_ack_i;
  assign w_burst_cfg = (cfg_burst_i == 4'd0)    ? 4'd1     :
                       (cfg_burst_i > BurstMax) ? BurstMax : cfg_burst_i;
  // The generator restarts from live cfg at start and from latched cfg before read-back.
  assign w_restart   = ((r_state == StIdle) & start_i) | ((r_state == StWrGap) & (r_rem == '0));
  assign w_gen_pat   = (r_state == StIdle) ? pat_e'(cfg_pat_i) : r_pat;
  assign w_gen_seed  = (r_state == StIdle) ? cfg_seed_i : r_seed;

  wbpg_pattern_gen #(
    .DW    (DW),
    .LEN_W (LEN_W)
  ) u_pattern_gen (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_restart (w_restart),
    .i_advance (w_ack),
    .i_pat     (w_gen_pat),
    .i_seed    (w_gen_seed),
    .o_word    (w_word)
  );

`ifdef WBPG_TIMEOUT_EN
  logic [11:0] r_wdog;
  logic        r_timeout;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_addr      <= '0;
      r_first_err <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_burst     <= 4'd1;
      r_bleft     <= '0;
      r_pat       <= PatIncr;
      r_seed      <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cti       <= 3'b000;
      r_err       <= '0;
`ifdef WBPG_TIMEOUT_EN
      r_wdog      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_busy <= 1'b0;
          if (start_i) begin
            r_base      <= cfg_base_i;
            r_addr      <= cfg_base_i;
            r_len       <= cfg_len_i;
            r_rem       <= cfg_len_i;
            r_burst     <= w_burst_cfg;
            r_pat       <= pat_e'(cfg_pat_i);
            r_seed      <= cfg_seed_i;
            r_err       <= '0;
            r_first_err <= '0;
            r_busy      <= 1'b1;
`ifdef WBPG_TIMEOUT_EN
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
`endif
            if (cfg_len_i == '0) begin
              r_state <= StFin;
            end else begin
              r_state <= StWr;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_bleft <= first_bl(cfg_len_i, w_burst_cfg);
              r_cti   <= cti_of(first_bl(cfg_len_i, w_burst_cfg));
            end
          end
        end
        StWr, StRd: begin
          if (w_ack) begin
            r_addr <= r_addr + AddrStep;
            r_rem  <= r_rem - LEN_W'(1);
            if ((r_state == StRd) && (wb_dat_i != w_word)) begin
              if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
              if (r_err == '0) r_first_err <= r_addr;
            end
            if (r_bleft == 4'd1) begin
              r_cyc <= 1'b0;
              r_stb <= 1'b0;
              r_cti <= 3'b000;
              if (r_state == StWr) r_state <= StWrGap;
              else                 r_state <= StRdGap;
            end else begin
              r_bleft <= r_bleft - 4'd1;
              r_cti   <= cti_of(r_bleft - 4'd1);
            end
          end
`ifdef WBPG_TIMEOUT_EN
          if (w_ack) begin
            r_wdog <= '0;
          end else if (r_wdog == WDOG_LIMIT) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_cti     <= 3'b000;
            r_timeout <= 1'b1;
            r_state   <= StFin;
          end else begin
            r_wdog <= r_wdog + 12'd1;
          end
`endif
        end
        StWrGap: begin
          r_cyc <= 1'b1;
          r_stb <= 1'b1;
          if (r_rem == '0) begin
            r_state <= StRd;
            r_we    <= 1'b0;
            r_addr  <= r_base;
            r_rem   <= r_len;
            r_bleft <= first_bl(r_len, r_burst);
            r_cti   <= cti_of(first_bl(r_len, r_burst));
          end else begin
            r_state <= StWr;
            r_bleft <= first_bl(r_rem, r_burst);
            r_cti   <= cti_of(first_bl(r_rem, r_burst));
          end
        end
        StRdGap: begin
          if (r_rem == '0) begin
            r_state <= StFin;
          end else begin
            r_state <= StRd;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_bleft <= first_bl(r_rem, r_burst);
            r_cti   <= cti_of(first_bl(r_rem, r_burst));
          end
        end
        StFin: begin
          r_done  <= 1'b1;
          r_we    <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign wb_cyc_o         = r_cyc;
  assign wb_stb_o         = r_stb;
  assign wb_we_o          = r_we;
  assign wb_addr_o        = r_addr;
  assign wb_dat_o         = w_word;
  assign wb_sel_o         = '1;
  assign wb_cti_o         = r_cti;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign err_cnt_o        = r_err;
  assign first_err_addr_o = r_first_err;
`ifdef WBPG_TIMEOUT_EN
  assign timeout_o        = r_timeout;
`else
  assign timeout_o        = 1'b0;
`endif

endmodule
